pulse_train_analyzer: RTL and testbench
=======================================

# pulse_train_analyzer

Measurement block at the output of the digital synthesizer. It watches the 12-bit synthesizer sample stream and reconstructs the pulse envelope of the burst. For every pulse it reports the impulse width and the leading-edge-to-leading-edge period in clock cycles, plus a running pulse count. It is the loop-back checker that confirms the generated impulse/period schedule (including vobulated periods) in simulation and on hardware.

## Interface

**Parameters**
- `DATA_WIDTH`, 12: sample width; samples are offset binary.
- `MIDSCALE`, 2048: zero-signal code.
- `THRESHOLD`, 64: a sample is *active* when |DATA − MIDSCALE| > THRESHOLD.
- `GAP_CYCLES`, 16: number of consecutive quiet samples that ends a pulse. Range 2..255.
- `CNT_WIDTH`, 24: width of the measurement counters.

**Ports**
- `CLK`, in, 1: system clock; the sample rate equals the clock rate.
- `RESET`, in, 1: asynchronous, active-low reset.
- `ENABLE`, in, 1: when low, the block is held in IDLE and counters are frozen at 0.
- `CLEAR`, in, 1: synchronous clear of state, counters and outputs.
- `DATA`, in, DATA_WIDTH: synthesizer output sample.
- `ENVELOPE`, out, 1: reconstructed pulse envelope.
- `IMP_WIDTH`, out, CNT_WIDTH: width of the last completed pulse, in cycles.
- `WIDTH_VALID`, out, 1: one-cycle strobe when `IMP_WIDTH` updates.
- `IMP_PERIOD`, out, CNT_WIDTH: distance between the last two leading edges, in cycles.
- `PERIOD_VALID`, out, 1: one-cycle strobe when `IMP_PERIOD` updates.
- `IMP_COUNT`, out, 6: number of completed pulses, modulo 64.
- `OVF`, out, 1: sticky flag, set when any counter saturates.

## Operation

- The input is registered into `d_r`. `act = |d_r − MIDSCALE| > THRESHOLD`, computed in DATA_WIDTH+1 signed arithmetic.
- **IDLE** (after reset, CLEAR, or ENABLE low):
  - On `act` → ON.
  - No period reference exists yet.
- **ON**:
  - `wcnt` increments each cycle.
  - On `!act` → GAP with `gcnt` = 1.
- **GAP**:
  - On `act` → ON. The gap is absorbed into the pulse, `wcnt` keeps counting through the gap, and `gcnt` clears. This covers carrier zero crossings and PSK phase flips.
  - On `!act`, `gcnt` increments. When `gcnt` reaches GAP_CYCLES → OFF, and the pulse end is declared.
- **On pulse end**:
  - `IMP_WIDTH` = cycles from the first active sample through the last active sample.
  - `WIDTH_VALID` pulses for one cycle.
  - `IMP_COUNT` increments, wrapping 63 → 0.
- **OFF**:
  - `pcnt` keeps running.
  - On `act` → ON (leading edge).
- **Leading edge handling**:
  - At every leading edge `pcnt` restarts at 1.
  - At every leading edge except the first after IDLE, `IMP_PERIOD` is loaded with the old `pcnt` and `PERIOD_VALID` pulses.
- **Counter saturation**: `wcnt` and `pcnt` saturate at 2^CNT_WIDTH − 1 and set `OVF`. A saturated value is reported as-is.
- `ENVELOPE` = 1 in ON and GAP, 0 otherwise.
- **Simultaneous events**: CLEAR has priority over everything except RESET. ENABLE low has priority over DATA.
- **Reset or CLEAR mid-pulse**: the partial measurement is discarded with no strobe. The next active sample counts as a first leading edge.

## Timing

- **Reset values**: all outputs are 0 and the state is IDLE.
- **Leading-edge latency**: DATA active at edge n gives `ENVELOPE` = 1 after edge n+2. `PERIOD_VALID` and `IMP_PERIOD` update after the same edge n+2.
- **Pulse-end latency**: for last active sample at edge m, followed by quiet samples:
  - `ENVELOPE` falls after edge m+GAP_CYCLES+2.
  - `WIDTH_VALID`, `IMP_WIDTH` and `IMP_COUNT` update after that same edge.
- **Strobes**: exactly one cycle wide and never asserted while ENABLE is low.
- **Holding**: `IMP_WIDTH` and `IMP_PERIOD` hold their values between strobes.
- **Back-to-back pulses**: a leading edge in the same cycle as a pulse-end declaration cannot occur, because a pulse end requires GAP_CYCLES quiet samples.

## Test plan

1. **Quiet input**: DATA = 2048 ± 30 noise for 10,000 cycles. Required: `ENVELOPE` = 0, no strobes, `IMP_COUNT` = 0.
2. **Square pulse train**:
   - Stimulus: DATA = 2548 for 100 cycles, then 2048 for 200 cycles, repeated 3 times.
   - Required widths: three `WIDTH_VALID` strobes, each with `IMP_WIDTH` = 100.
   - Required periods: two `PERIOD_VALID` strobes, each with `IMP_PERIOD` = 300.
   - Required count: `IMP_COUNT` = 3.
3. **Real synthesizer signal**:
   - Stimulus: full-scale sine with periodic 10-sample near-midscale stretches (GAP_CYCLES = 16), 1000-cycle pulse.
   - Required: a single pulse with `IMP_WIDTH` = 1000 and no mid-pulse `ENVELOPE` drop.
4. **Vobulated periods**: pulses of 500 cycles, leading edges spaced 1000, 1500, 2000 cycles. Required: `IMP_PERIOD` sequence 1000, 1500, 2000.
5. **Saturation** (CNT_WIDTH = 8): 300-cycle active pulse. Required: `IMP_WIDTH` = 255 and `OVF` = 1 (sticky until RESET or CLEAR).
6. **Reset mid-pulse**:
   - Stimulus: RESET low at cycle 50 of a 100-cycle pulse, released, then a fresh 80-cycle pulse.
   - Required: outputs are 0 during reset, and the only strobe afterwards is `WIDTH_VALID` with 80.
   - Required: no `PERIOD_VALID`.

Source files
------------

// File: rtl/pulse_train_analyzer.sv
// Rebuilds the pulse envelope of the synthesizer sample stream and measures
// per-pulse width, leading-edge-to-leading-edge period and a running pulse count.
module pulse_train_analyzer #(
    parameter int DATA_WIDTH = 12,
    parameter int MIDSCALE   = 2048,
    parameter int THRESHOLD  = 64,
    parameter int GAP_CYCLES = 16,
    parameter int CNT_WIDTH  = 24
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ENABLE,
    input  logic                  CLEAR,
    input  logic [DATA_WIDTH-1:0] DATA,
    output logic                  ENVELOPE,
    output logic [CNT_WIDTH-1:0]  IMP_WIDTH,
    output logic                  WIDTH_VALID,
    output logic [CNT_WIDTH-1:0]  IMP_PERIOD,
    output logic                  PERIOD_VALID,
    output logic [5:0]            IMP_COUNT,
    output logic                  OVF
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2,
        ST_OFF  = 2'd3
    } state_e;

    localparam logic signed [DATA_WIDTH:0] MID_C   = (DATA_WIDTH+1)'(MIDSCALE);
    localparam logic signed [DATA_WIDTH:0] THR_C   = (DATA_WIDTH+1)'(THRESHOLD);
    localparam logic [DATA_WIDTH-1:0]      MID_U_C = DATA_WIDTH'(MIDSCALE);
    localparam logic [7:0]                 GAP_C   = 8'(GAP_CYCLES);
    localparam logic [CNT_WIDTH-1:0]       ONE_C   = CNT_WIDTH'(1);

    // MSB of the result flags an add that was clamped at the all-ones value.
    function automatic logic [CNT_WIDTH:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [CNT_WIDTH-1:0] b);
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[CNT_WIDTH]) begin
            sat_add = {1'b1, {CNT_WIDTH{1'b1}}};
        end else begin
            sat_add = sum;
        end
    endfunction

    logic [DATA_WIDTH-1:0]      d_q;
    logic                       act_q;
    state_e                     state_q;
    logic [CNT_WIDTH-1:0]       wcnt_q, pcnt_q, width_q, period_q;
    logic [7:0]                 gcnt_q;
    logic                       ref_q, env_q, wvalid_q, pvalid_q, ovf_q;
    logic [5:0]                 count_q;

    logic signed [DATA_WIDTH:0] diff_d, mag_d;
    logic                       act_d, lead_d, wsat_d, psat_d;
    logic [CNT_WIDTH:0]         winc_d, wabs_d, pinc_d;
    logic [7:0]                 gcnt_d;

    // Activity detect: magnitude of the offset-binary sample around midscale.
    always_comb begin
        diff_d = $signed({1'b0, d_q}) - MID_C;
        if (diff_d < 0) begin
            mag_d = -diff_d;
        end else begin
            mag_d = diff_d;
        end
        act_d = (mag_d > THR_C);
    end

    // Saturating counter candidates and event decodes for the FSM.
    always_comb begin
        winc_d = sat_add(wcnt_q, ONE_C);
        wabs_d = sat_add(wcnt_q, CNT_WIDTH'(gcnt_q) + ONE_C);
        pinc_d = sat_add(pcnt_q, ONE_C);
        gcnt_d = gcnt_q + 8'd1;
        lead_d = act_q && ((state_q == ST_IDLE) || (state_q == ST_OFF));
        if (state_q == ST_ON) begin
            wsat_d = act_q && winc_d[CNT_WIDTH];
        end else if (state_q == ST_GAP) begin
            wsat_d = act_q && wabs_d[CNT_WIDTH];
        end else begin
            wsat_d = 1'b0;
        end
        psat_d = ref_q && !lead_d && pinc_d[CNT_WIDTH];
    end

    // Two-stage input pipeline; idles at midscale so reset/clear never look active.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            d_q   <= MID_U_C;
            act_q <= 1'b0;
        end else if (CLEAR) begin
            d_q   <= MID_U_C;
            act_q <= 1'b0;
        end else begin
            d_q   <= DATA;
            act_q <= act_d;
        end
    end

    // Envelope FSM with measurement counters and registered result outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET || CLEAR) begin
            state_q  <= ST_IDLE;
            wcnt_q   <= '0;
            pcnt_q   <= '0;
            gcnt_q   <= 8'd0;
            ref_q    <= 1'b0;
            env_q    <= 1'b0;
            width_q  <= '0;
            wvalid_q <= 1'b0;
            period_q <= '0;
            pvalid_q <= 1'b0;
            count_q  <= 6'd0;
            ovf_q    <= 1'b0;
        end else begin
            wvalid_q <= 1'b0;
            pvalid_q <= 1'b0;
            if (!ENABLE) begin
                state_q <= ST_IDLE;
                wcnt_q  <= '0;
                pcnt_q  <= '0;
                gcnt_q  <= 8'd0;
                ref_q   <= 1'b0;
                env_q   <= 1'b0;
            end else begin
                if (lead_d) begin
                    pcnt_q <= ONE_C;
                    ref_q  <= 1'b1;
                    if (ref_q) begin
                        period_q <= pcnt_q;
                        pvalid_q <= 1'b1;
                    end
                end else if (ref_q) begin
                    pcnt_q <= pinc_d[CNT_WIDTH-1:0];
                end
                ovf_q <= ovf_q | wsat_d | psat_d;
                case (state_q)
                    ST_IDLE, ST_OFF: begin
                        if (act_q) begin
                            state_q <= ST_ON;
                            env_q   <= 1'b1;
                            wcnt_q  <= ONE_C;
                            gcnt_q  <= 8'd0;
                        end
                    end
                    ST_ON: begin
                        if (act_q) begin
                            wcnt_q <= winc_d[CNT_WIDTH-1:0];
                        end else begin
                            state_q <= ST_GAP;
                            gcnt_q  <= 8'd1;
                        end
                    end
                    // A short quiet run is folded back into the pulse width.
                    ST_GAP: begin
                        if (act_q) begin
                            state_q <= ST_ON;
                            wcnt_q  <= wabs_d[CNT_WIDTH-1:0];
                            gcnt_q  <= 8'd0;
                        end else if (gcnt_d == GAP_C) begin
                            state_q  <= ST_OFF;
                            env_q    <= 1'b0;
                            gcnt_q   <= 8'd0;
                            width_q  <= wcnt_q;
                            wvalid_q <= 1'b1;
                            count_q  <= count_q + 6'd1;
                        end else begin
                            gcnt_q <= gcnt_d;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        env_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ENVELOPE     = env_q;
    assign IMP_WIDTH    = width_q;
    assign WIDTH_VALID  = wvalid_q;
    assign IMP_PERIOD   = period_q;
    assign PERIOD_VALID = pvalid_q;
    assign IMP_COUNT    = count_q;
    assign OVF          = ovf_q;

endmodule

// File: tb/tb_pulse_train_analyzer.sv
// Directed bench for pulse_train_analyzer: expected widths/periods are queued as
// stimulus is driven and popped by a monitor whenever the DUT strobes.
module tb_pulse_train_analyzer;

    logic        CLK = 1'b0;
    logic        RESET, ENABLE, CLEAR;
    logic [11:0] DATA;

    logic        ENVELOPE, WIDTH_VALID, PERIOD_VALID, OVF;
    logic [23:0] IMP_WIDTH, IMP_PERIOD;
    logic [5:0]  IMP_COUNT;

    logic        env_8, wv_8, pv_8, ovf_8;
    logic [7:0]  width_8, period_8;
    logic [5:0]  count_8;

    int errors = 0;
    int checks = 0;
    int wv_cnt = 0, pv_cnt = 0, env_hi_cnt = 0, env_fall_cnt = 0;
    logic env_prev = 1'b0;
    bit   sat_arm  = 1'b0;
    int   exp_w[$], exp_p[$], exp_w8[$];

    pulse_train_analyzer u_dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .CLEAR(CLEAR), .DATA(DATA),
        .ENVELOPE(ENVELOPE), .IMP_WIDTH(IMP_WIDTH), .WIDTH_VALID(WIDTH_VALID),
        .IMP_PERIOD(IMP_PERIOD), .PERIOD_VALID(PERIOD_VALID),
        .IMP_COUNT(IMP_COUNT), .OVF(OVF)
    );

    pulse_train_analyzer #(.CNT_WIDTH(8)) u_sat (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .CLEAR(CLEAR), .DATA(DATA),
        .ENVELOPE(env_8), .IMP_WIDTH(width_8), .WIDTH_VALID(wv_8),
        .IMP_PERIOD(period_8), .PERIOD_VALID(pv_8),
        .IMP_COUNT(count_8), .OVF(ovf_8)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] main_outs();
        return {6'd0, ENVELOPE, IMP_WIDTH, WIDTH_VALID, IMP_PERIOD, PERIOD_VALID, IMP_COUNT, OVF};
    endfunction

    task automatic send(input int v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            DATA = 12'(v);
        end
    endtask

    task automatic do_clear();
        @(negedge CLK);
        CLEAR = 1'b1;
        @(negedge CLK);
        CLEAR = 1'b0;
        check("clear_outputs", main_outs(), 64'd0);
    endtask

    // Scoreboard monitor, sampling 2 time units after each rising edge.
    always begin
        @(posedge CLK);
        #2;
        if (WIDTH_VALID) begin
            wv_cnt++;
            if (exp_w.size() == 0) check("width_strobe_expected", 64'(exp_w.size()), 64'd1);
            else check("imp_width", 64'(IMP_WIDTH), 64'(exp_w.pop_front()));
        end
        if (PERIOD_VALID) begin
            pv_cnt++;
            if (exp_p.size() == 0) check("period_strobe_expected", 64'(exp_p.size()), 64'd1);
            else check("imp_period", 64'(IMP_PERIOD), 64'(exp_p.pop_front()));
        end
        if (sat_arm && wv_8) begin
            if (exp_w8.size() == 0) check("sat_strobe_expected", 64'(exp_w8.size()), 64'd1);
            else check("sat_imp_width", 64'(width_8), 64'(exp_w8.pop_front()));
        end
        if (!ENABLE) check("strobe_while_disabled", {62'd0, WIDTH_VALID, PERIOD_VALID}, 64'd0);
        if (ENVELOPE) env_hi_cnt++;
        if (env_prev && !ENVELOPE) env_fall_cnt++;
        env_prev = ENVELOPE;
    end

    initial begin
        int  b_w, b_p, b_e, b_f;
        int  sp[4];
        int  v;
        real ang;

        RESET  = 1'b0;
        ENABLE = 1'b1;
        CLEAR  = 1'b0;
        DATA   = 12'd2048;
        repeat (3) @(negedge CLK);
        check("reset_outputs", main_outs(), 64'd0);
        RESET = 1'b1;

        // Quiet noise around midscale.
        b_w = wv_cnt; b_p = pv_cnt; b_e = env_hi_cnt;
        for (int i = 0; i < 10000; i++) begin
            @(negedge CLK);
            DATA = 12'(2018 + int'($urandom_range(60)));
        end
        send(2048, 5);
        check("quiet_envelope_cycles", 64'(env_hi_cnt - b_e), 64'd0);
        check("quiet_width_strobes", 64'(wv_cnt - b_w), 64'd0);
        check("quiet_period_strobes", 64'(pv_cnt - b_p), 64'd0);
        check("quiet_count", 64'(IMP_COUNT), 64'd0);

        // Square train: 100 on / 200 off, three times.
        do_clear();
        for (int k = 0; k < 3; k++) begin
            exp_w.push_back(100);
            if (k > 0) exp_p.push_back(300);
            send(2548, 100);
            send(2048, 200);
        end
        check("square_count", 64'(IMP_COUNT), 64'd3);
        check("square_width_hold", 64'(IMP_WIDTH), 64'd100);
        check("square_period_hold", 64'(IMP_PERIOD), 64'd300);
        check("square_wq_empty", 64'(exp_w.size()), 64'd0);
        check("square_pq_empty", 64'(exp_p.size()), 64'd0);

        // Threshold boundary: offset of exactly 64 is quiet, 65 is active.
        do_clear();
        send(2112, 40);
        send(1984, 40);
        exp_w.push_back(30);
        send(1983, 30);
        send(2048, 30);
        check("thresh_count", 64'(IMP_COUNT), 64'd1);
        check("thresh_wq_empty", 64'(exp_w.size()), 64'd0);

        // Gap boundary: 15 quiet samples are absorbed, 16 end the pulse.
        do_clear();
        exp_w.push_back(55);
        send(2548, 20); send(2048, 15); send(2548, 20); send(2048, 16);
        exp_w.push_back(20); exp_p.push_back(71);
        send(2548, 20); send(2048, 16);
        exp_w.push_back(20); exp_p.push_back(36);
        send(2548, 20); send(2048, 30);
        check("gap_count", 64'(IMP_COUNT), 64'd3);
        check("gap_wq_empty", 64'(exp_w.size()), 64'd0);
        check("gap_pq_empty", 64'(exp_p.size()), 64'd0);

        // Sine burst with 10-sample near-midscale stretches.
        do_clear();
        b_f = env_fall_cnt;
        exp_w.push_back(1000);
        for (int i = 0; i < 1000; i++) begin
            if ((i % 100) >= 40 && (i % 100) < 50) begin
                v = 2048;
            end else begin
                ang = 2.0 * 3.14159265358979 * (real'(i) + 0.5) / 20.0;
                v = 2048 + $rtoi(2047.0 * $sin(ang));
            end
            send(v, 1);
        end
        send(2048, 40);
        check("sine_env_falls", 64'(env_fall_cnt - b_f), 64'd1);
        check("sine_count", 64'(IMP_COUNT), 64'd1);
        check("sine_wq_empty", 64'(exp_w.size()), 64'd0);

        // ENABLE low mid-pulse drops it silently; next pulse is a first edge.
        do_clear();
        b_p = pv_cnt;
        send(2548, 20);
        @(negedge CLK);
        ENABLE = 1'b0;
        send(2548, 30);
        check("disabled_envelope", 64'(ENVELOPE), 64'd0);
        send(2048, 30);
        @(negedge CLK);
        ENABLE = 1'b1;
        send(2048, 20);
        exp_w.push_back(40);
        send(2548, 40);
        send(2048, 30);
        check("enable_period_strobes", 64'(pv_cnt - b_p), 64'd0);
        check("enable_count", 64'(IMP_COUNT), 64'd1);
        check("enable_wq_empty", 64'(exp_w.size()), 64'd0);

        // Vobulated periods with negative-going pulses.
        do_clear();
        sp = '{1000, 1500, 2000, 600};
        for (int k = 0; k < 4; k++) begin
            exp_w.push_back(500);
            if (k > 0) exp_p.push_back(sp[k-1]);
            send(1548, 500);
            send(2048, sp[k] - 500);
        end
        check("vob_period_hold", 64'(IMP_PERIOD), 64'd2000);
        check("vob_count", 64'(IMP_COUNT), 64'd4);
        check("vob_wq_empty", 64'(exp_w.size()), 64'd0);
        check("vob_pq_empty", 64'(exp_p.size()), 64'd0);

        // Saturation on the 8-bit counter instance.
        do_clear();
        check("sat_ovf_initial", 64'(ovf_8), 64'd0);
        sat_arm = 1'b1;
        exp_w.push_back(300);
        exp_w8.push_back(255);
        send(2548, 300);
        send(2048, 40);
        check("sat_ovf", 64'(ovf_8), 64'd1);
        check("sat_width_hold", 64'(width_8), 64'd255);
        check("sat_w8q_empty", 64'(exp_w8.size()), 64'd0);
        check("main_no_ovf", 64'(OVF), 64'd0);
        sat_arm = 1'b0;
        send(2048, 10);
        check("sat_ovf_sticky", 64'(ovf_8), 64'd1);
        do_clear();
        check("sat_ovf_cleared", 64'(ovf_8), 64'd0);

        // Reset in the middle of a pulse, then a fresh 80-cycle pulse.
        do_clear();
        b_p = pv_cnt;
        send(2048, 5);
        send(2548, 50);
        @(negedge CLK);
        RESET = 1'b0;
        send(2548, 49);
        check("reset_mid_outputs", main_outs(), 64'd0);
        send(2048, 10);
        check("reset_hold_outputs", main_outs(), 64'd0);
        @(negedge CLK);
        RESET = 1'b1;
        send(2048, 20);
        exp_w.push_back(80);
        send(2548, 80);
        send(2048, 40);
        check("reset_period_strobes", 64'(pv_cnt - b_p), 64'd0);
        check("reset_count", 64'(IMP_COUNT), 64'd1);
        check("reset_wq_empty", 64'(exp_w.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
